// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-strobed memory and its response pipeline.
package memory_pkg;

  localparam int MEM_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MEM_WIDTH-1:0] data;
    logic                 err;
  } resp_stage_t;

  // One byte lane of a strobed write: take the new byte only where its strobe is set.
  function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       strb);
    logic [7:0] merged;
    if (strb) begin
      merged = new_byte;
    end else begin
      merged = old_byte;
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// RD_LAT-deep response stage chain. Every stage moves together; the whole chain
// freezes while the last stage holds a response the consumer has not taken.
module mem_resp_pipe
  import memory_pkg::*;
#(
  parameter int  RD_LAT = 1,
  parameter type resp_t = resp_stage_t
) (
  input  logic  clk,
  input  logic  res,
  input  logic  i_rready,
  input  resp_t i_resp,
  output resp_t o_resp,
  output logic  o_advance
);

  resp_t r_stage [RD_LAT];
  logic  w_advance;

  assign w_advance = !(r_stage[RD_LAT-1].valid && !i_rready);
  assign o_advance = w_advance;
  assign o_resp    = r_stage[RD_LAT-1];

  // Stage shift register, flushed by reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      for (int k = 0; k < RD_LAT; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_advance) begin
      r_stage[0] <= i_resp;
      for (int k = 1; k < RD_LAT; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

endmodule

// File: rtl/memory_strb.sv
// Single-port word memory with byte strobes, post-reset clear sequence,
// out-of-range error responses and an in-order backpressured response channel.
module memory_strb
  import memory_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 16,
  parameter  int ADDR_WIDTH = 5,
  parameter  int RD_LAT     = 1,
  localparam int STRB_WIDTH = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Same layout as resp_stage_t, but sized to this instance's data width.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             err;
  } resp_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_accept;
  logic             w_advance;
  logic [WIDTH-1:0] w_merged;
  resp_t            w_resp_in;
  resp_t            w_resp_out;

  assign w_idx      = addr[IDX_W-1:0];
  assign w_in_range = (32'(addr) < 32'(DEPTH));
  assign ready      = (r_state == ST_RUN) && w_advance;
  assign w_accept   = valid && ready;

  // State and clear-counter registers.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear sequence walks every word once, then hands over to normal operation.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + IDX_W'(1);
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Byte-lane merge of the addressed word with the incoming write.
  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < STRB_WIDTH; i++) begin
      w_merged[8*i +: 8] = strb_merge(r_mem[w_idx][8*i +: 8], wdata[8*i +: 8], wstrb[i]);
    end
  end

  // Memory array: cleared during init, strobed writes afterwards, untouched in reset.
  always_ff @(posedge clk) begin
    if (res) begin
      if (r_state == ST_INIT) begin
        r_mem[r_cnt] <= '0;
      end else if (w_accept && wr_rd && w_in_range) begin
        r_mem[w_idx] <= w_merged;
      end
    end
  end

  // Response entering stage 1; reads capture the word as it stands at the accept edge.
  always_comb begin
    w_resp_in       = '0;
    w_resp_in.valid = w_accept;
    if (w_accept && !w_in_range) begin
      w_resp_in.err = 1'b1;
    end else if (w_accept && !wr_rd) begin
      w_resp_in.data = r_mem[w_idx];
    end else begin
      w_resp_in.data = '0;
    end
  end

  mem_resp_pipe #(
    .RD_LAT (RD_LAT),
    .resp_t (resp_t)
  ) u_resp_pipe (
    .clk       (clk),
    .res       (res),
    .i_rready  (rready),
    .i_resp    (w_resp_in),
    .o_resp    (w_resp_out),
    .o_advance (w_advance)
  );

  assign rvalid = w_resp_out.valid;
  assign rdata  = w_resp_out.data;
  assign err    = w_resp_out.err;

endmodule

// File: tb/tb_memory_strb.sv
// Drives an RD_LAT=1 and an RD_LAT=2 instance with the same request stream and
// checks both against a word-array / response-queue reference model.
module tb_memory_strb;

  localparam int DEPTH = 16;
  localparam int QN    = 512;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_e;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_edge;
    bit          clean;
  } resp_e;

  logic        clk    = 1'b0;
  logic        res    = 1'b0;
  logic        rready = 1'b1;
  logic        valid_s [2];
  logic        wr_rd_s [2];
  logic [4:0]  addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  wstrb_s [2];
  logic        ready_a, ready_b, rvalid_a, rvalid_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    edges    = 0;
  int    init_cnt = 0;
  bit    armed    = 1'b0;
  bit    after_reset = 1'b0;
  logic [31:0] m_mem [2][DEPTH];
  req_e  pend [2][QN];
  resp_e expq [2][QN];
  int    p_head [2];
  int    p_tail [2];
  int    e_head [2];
  int    e_tail [2];
  bit    seen [2];
  bit    prev_hold [2];

  always #5 clk = ~clk;

  memory_strb #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .RD_LAT(1)) u_lat1 (
    .clk(clk), .res(res), .valid(valid_s[0]), .ready(ready_a), .wr_rd(wr_rd_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .wstrb(wstrb_s[0]), .rvalid(rvalid_a),
    .rready(rready), .rdata(rdata_a), .err(err_a)
  );

  memory_strb #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .RD_LAT(2)) u_lat2 (
    .clk(clk), .res(res), .valid(valid_s[1]), .ready(ready_b), .wr_rd(wr_rd_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .wstrb(wstrb_s[1]), .rvalid(rvalid_b),
    .rready(rready), .rdata(rdata_b), .err(err_b)
  );

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat%0d observed=%h expected=%h", tag, k + 1, obs, exp);
    end
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int k = 0; k < 2; k++) begin
      n += (p_tail[k] - p_head[k]) + (e_tail[k] - e_head[k]);
    end
    return n;
  endfunction

  task automatic push_req(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < 2; k++) begin
      pend[k][p_tail[k]].wr    = wr;
      pend[k][p_tail[k]].addr  = a;
      pend[k][p_tail[k]].wdata = d;
      pend[k][p_tail[k]].wstrb = s;
      p_tail[k]++;
    end
  endtask

  // One clock: drive, sample and check both DUTs, then advance the model at the edge.
  task automatic tick();
    logic        rdy [2];
    logic        rv  [2];
    logic        er  [2];
    logic [31:0] rd  [2];
    bit          acc [2];
    bit          hs  [2];
    logic        res_at;
    logic        exp_rdy;
    req_e        r;
    resp_e       e;
    for (int k = 0; k < 2; k++) begin
      if (p_head[k] != p_tail[k]) begin
        r          = pend[k][p_head[k]];
        valid_s[k] = 1'b1;
        wr_rd_s[k] = r.wr;
        addr_s[k]  = r.addr;
        wdata_s[k] = r.wdata;
        wstrb_s[k] = r.wstrb;
      end else begin
        valid_s[k] = 1'b0;
        wr_rd_s[k] = 1'($urandom_range(0, 1));
        addr_s[k]  = 5'($urandom_range(0, 31));
        wdata_s[k] = $urandom;
        wstrb_s[k] = 4'($urandom_range(0, 15));
      end
    end
    #1;
    rdy[0] = ready_a;  rv[0] = rvalid_a;  rd[0] = rdata_a;  er[0] = err_a;
    rdy[1] = ready_b;  rv[1] = rvalid_b;  rd[1] = rdata_b;  er[1] = err_b;
    for (int k = 0; k < 2; k++) begin
      if (armed) begin
        if (after_reset) begin
          chk("rvalid_after_reset", k, 64'(rv[k]), 64'(0));
          chk("rdata_after_reset", k, 64'(rd[k]), 64'(0));
          chk("err_after_reset", k, 64'(er[k]), 64'(0));
        end
        exp_rdy = (init_cnt == DEPTH) && !(rv[k] && !rready);
        chk("ready", k, 64'(rdy[k]), 64'(exp_rdy));
        if (prev_hold[k]) begin
          chk("held_rvalid", k, 64'(rv[k]), 64'(1));
        end
        if (rv[k]) begin
          if (e_head[k] == e_tail[k]) begin
            chk("spurious_rvalid", k, 64'(rv[k]), 64'(0));
          end else begin
            e = expq[k][e_head[k]];
            chk("rdata", k, 64'(rd[k]), 64'(e.data));
            chk("err", k, 64'(er[k]), 64'(e.err));
            if (!seen[k]) begin
              seen[k] = 1'b1;
              if (e.clean) begin
                chk("latency", k, 64'(edges), 64'(e.acc_edge + k));
              end
            end
          end
        end
      end
      acc[k]       = valid_s[k] && rdy[k];
      hs[k]        = rv[k] && rready;
      prev_hold[k] = rv[k] && !rready;
      if (!rready) begin
        for (int j = e_head[k]; j < e_tail[k]; j++) begin
          expq[k][j].clean = 1'b0;
        end
      end
    end
    res_at = res;
    @(posedge clk);
    edges++;
    if (!res_at) begin
      armed       = 1'b1;
      after_reset = 1'b1;
      init_cnt    = 0;
      for (int k = 0; k < 2; k++) begin
        p_head[k] = p_tail[k];
        e_head[k] = e_tail[k];
        seen[k]      = 1'b0;
        prev_hold[k] = 1'b0;
      end
    end else begin
      after_reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (hs[k] && (e_head[k] != e_tail[k])) begin
          e_head[k]++;
          seen[k] = 1'b0;
        end
        if (acc[k]) begin
          r = pend[k][p_head[k]];
          p_head[k]++;
          e.acc_edge = edges;
          e.clean    = 1'b1;
          e.data     = 32'd0;
          e.err      = 1'b0;
          if (r.addr >= 5'd16) begin
            e.err = 1'b1;
          end else if (r.wr) begin
            for (int b = 0; b < 4; b++) begin
              if (r.wstrb[b]) m_mem[k][r.addr[3:0]][8*b +: 8] = r.wdata[8*b +: 8];
            end
          end else begin
            e.data = m_mem[k][r.addr[3:0]];
          end
          expq[k][e_tail[k]] = e;
          e_tail[k]++;
        end
      end
      if (init_cnt < DEPTH) begin
        m_mem[0][init_cnt] = 32'd0;
        m_mem[1][init_cnt] = 32'd0;
        init_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rready = 1'b1;
    while ((n < budget) && (busy_count() != 0)) begin
      tick();
      n++;
    end
    chk("drain_timeout", 0, 64'(busy_count()), 64'(0));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      p_head[k] = 0;  p_tail[k] = 0;  e_head[k] = 0;  e_tail[k] = 0;
      seen[k] = 1'b0;  prev_hold[k] = 1'b0;  valid_s[k] = 1'b0;
    end
    res    = 1'b0;
    rready = 1'b1;
    repeat (3) tick();
    res = 1'b1;

    for (int a = 0; a < 16; a++) push_req(1'b0, 5'(a), 32'd0, 4'd0);
    drain(200);

    push_req(1'b1, 5'd3, 32'hAABBCCDD, 4'hF);
    push_req(1'b1, 5'd3, 32'h11223344, 4'b0101);
    push_req(1'b0, 5'd3, 32'd0, 4'd0);
    push_req(1'b1, 5'd5, 32'h55555555, 4'h0);
    push_req(1'b0, 5'd5, 32'd0, 4'd0);
    drain(50);

    push_req(1'b1, 5'd7, 32'hDEADBEEF, 4'hF);
    push_req(1'b0, 5'd7, 32'd0, 4'd0);
    drain(50);

    push_req(1'b1, 5'd1, 32'h1, 4'hF);
    push_req(1'b1, 5'd2, 32'h2, 4'hF);
    push_req(1'b1, 5'd3, 32'h3, 4'hF);
    drain(50);
    rready = 1'b0;
    push_req(1'b0, 5'd1, 32'd0, 4'd0);
    push_req(1'b0, 5'd2, 32'd0, 4'd0);
    push_req(1'b0, 5'd3, 32'd0, 4'd0);
    repeat (6) tick();
    drain(50);

    push_req(1'b0, 5'd20, 32'd0, 4'd0);
    push_req(1'b1, 5'd16, 32'hFFFFFFFF, 4'hF);
    push_req(1'b0, 5'd0, 32'd0, 4'd0);
    push_req(1'b0, 5'd31, 32'd0, 4'd0);
    drain(50);

    rready = 1'b0;
    push_req(1'b0, 5'd3, 32'd0, 4'd0);
    push_req(1'b0, 5'd4, 32'd0, 4'd0);
    repeat (3) tick();
    res = 1'b0;
    repeat (2) tick();
    res    = 1'b1;
    rready = 1'b1;
    push_req(1'b0, 5'd3, 32'd0, 4'd0);
    drain(200);

    for (int i = 0; i < 250; i++) begin
      push_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
               4'($urandom_range(0, 15)));
      rready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_strb.md
# memory_strb

Parametrised single-port memory with per-byte write strobes, configurable read latency, and a response channel with backpressure. It adds a hardware clear sequence after reset and error responses for out-of-range addresses. Every accepted request produces exactly one in-order response. It is the successor to the basic valid/ready memory and serves as a local data store behind a request master.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8.
- `DEPTH`, 16: number of words.
- `ADDR_WIDTH`, 5: address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH. Addresses ≥ DEPTH are errors.
- `RD_LAT`, 1: response latency in stages; legal values are 1 and 2.
- `STRB_WIDTH`, WIDTH/8: number of byte strobes; derived, not overridden.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `res`  in  1  reset; synchronous, active-low.
- `valid`  in  1  request valid.
- `ready`  out  1  request accepted when valid && ready at a rising edge.
- `wr_rd`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_WIDTH  word address.
- `wdata`  in  WIDTH  write data.
- `wstrb`  in  STRB_WIDTH  byte enables; bit i covers wdata[8i+7:8i].
- `rvalid`  out  1  response valid.
- `rready`  in  1  response consumed when rvalid && rready at a rising edge.
- `rdata`  out  WIDTH  read data; 0 for write and error responses.
- `err`  out  1  response flag for an out-of-range address.

## Operation
- FSM states are ST_INIT and ST_RUN.
- **Reset (res = 0 at an edge):**
  - State goes to ST_INIT and the clear counter goes to 0.
  - ready=0, rvalid=0, rdata=0, err=0.
  - The response pipeline is flushed. Memory contents are not touched while res is low.
- **ST_INIT:**
  - Writes 0 to mem[counter] each cycle, then increments the counter.
  - Exits to ST_RUN after the write to DEPTH-1.
  - ready=0 throughout.
- **ST_RUN:**
  - ready = !(rvalid && !rready), so the pipeline stalls only while the output is held.
- **Accepted write, addr < DEPTH:**
  - Byte i of mem[addr] is updated only where wstrb[i]=1.
  - Response is rdata=0, err=0.
  - wstrb=0 is legal: memory is unchanged and the response is normal.
- **Accepted read, addr < DEPTH:**
  - mem[addr] is captured at the accept edge into stage 1.
  - Response is rdata=captured word, err=0.
- **Addr ≥ DEPTH (read or write):**
  - Memory is unchanged.
  - Response is rdata=0, err=1.
- **Read-after-write:** a read accepted the cycle after a write to the same address returns the new data. Only one request is accepted per cycle, so there is no same-cycle conflict.
- **Response pipeline:**
  - RD_LAT stages, each holding {valid, data, err}.
  - The whole pipeline advances when !(rvalid && !rready). Otherwise all stages hold.
  - rvalid, rdata and err are the last stage's contents.
- **Ordering:** responses are strictly in request order, never dropped or duplicated.
- **Held response:** while rvalid=1 and rready=0, rvalid, rdata and err are stable.

## Timing
- Request accepted at edge T → response visible after edge T+RD_LAT-1.
  - RD_LAT=1: visible immediately after the accept edge.
  - RD_LAT=2: one cycle later.
- Throughput is one request per cycle while rready=1.
- After res is raised: the first ST_INIT write happens at the first edge with res=1; ready rises after DEPTH edges.
- **Reset mid-operation:**
  - Takes effect at the next edge.
  - In-flight responses are discarded.
  - The full clear is re-run.
- rready is ignored while rvalid=0.

## Structure
- Package `memory_pkg` holds:
  - the state typedef (ST_INIT, ST_RUN);
  - the response-stage struct {valid, data, err};
  - function `strb_merge(old, new, strb)`.
- One sub-module, `mem_resp_pipe`: an RD_LAT-deep stallable stage register with the advance = !(out_valid && !rready) rule. It is instantiated once in `memory_strb`.
- The memory array, FSM and clear counter live in the top module.

## Test plan
All scenarios use WIDTH=32, DEPTH=16, ADDR_WIDTH=5.
1. **Init:** res=0 for 3 cycles, then 1 → ready=0 for exactly 16 cycles, then 1. Reads of addr 0..15 all return 0 with err=0.
2. **Byte strobes:** write addr 3 = 0xAABBCCDD with wstrb=4'hF, then write addr 3 = 0x11223344 with wstrb=4'b0101 → read addr 3 returns 0xAA22CC44.
3. **Read-after-write:** write addr 7 = 0xDEADBEEF, then read addr 7 back-to-back (RD_LAT=1 and RD_LAT=2) → rdata=0xDEADBEEF on the read response at the correct latency.
4. **Backpressure:** RD_LAT=2, rready=0, 3 back-to-back reads of addrs 1, 2, 3 (preloaded with 0x1, 0x2, 0x3).
   - ready drops once the output holds.
   - rdata stays stable while held.
   - After rready=1, responses are 0x1, 0x2, 0x3 in order.
5. **Errors:** read addr 20 → err=1, rdata=0. Write addr 16 = 0xFFFFFFFF → err=1, and addr 0 remains 0.
6. **Reset mid-operation:** res=0 with 2 responses in flight → rvalid=0 at the next edge and neither response ever appears. Memory is re-cleared, so addr 3 reads 0.
